// File: rtl/aes_cipher_core.sv
// Iterative AES encryption core: one full cipher round per clock, fed by the
// packed round-key schedule produced by the upstream key expansion block.
module aes_cipher_core #(
   parameter int Nr = 12,
   parameter int Nk = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [127:0]           plaintext,
   input  logic [(Nr+1)*128-1:0]  full_key,
   output logic                   busy,
   output logic                   done,
   output logic [127:0]           ciphertext
);

   localparam int unsigned NRU  = Nr;
   localparam int unsigned NKU  = Nk;
   localparam int unsigned NW   = 4 * (NRU + 1);
   localparam int unsigned G    = NKU * (NW / NKU);
   localparam logic [3:0]  LAST = 4'(Nr);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic {IDLE, RUN} fsm_t;

   fsm_t         fsm;
   logic [3:0]   round;
   logic [127:0] state;
   logic [127:0] rk [0:Nr];
   logic [127:0] round_key;
   logic [127:0] round_out;
   logic [7:0]   sb [16];
   logic [7:0]   sr [16];
   logic [31:0]  mc [4];

   // Full groups of Nk words are stored word-reversed; the partial tail group
   // sits in the top 128 bits in natural order.
   function automatic int unsigned word_off(input int unsigned k);
      if (k < G)
         return 32 * ((NKU - 1 - (k % NKU)) + NKU * (k / NKU));
      else
         return (NRU + 1) * 128 - 32 * (k - G + 1);
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   for (genvar r = 0; r <= Nr; r++) begin : g_rk
      assign rk[r] = {full_key[word_off(4*r)   +: 32],
                      full_key[word_off(4*r+1) +: 32],
                      full_key[word_off(4*r+2) +: 32],
                      full_key[word_off(4*r+3) +: 32]};
   end

   always_comb begin
      round_key = rk[round];
   end

   always_comb begin
      for (int unsigned i = 0; i < 16; i++)
         sb[i] = SBOX[state[127-8*i -: 8]];
   end

   // Byte i is row i%4, column i/4; row r rotates left by r columns.
   always_comb begin
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
   end

   always_comb begin
      for (int unsigned c = 0; c < 4; c++) begin
         mc[c] = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
         if (round != LAST)
            mc[c] = mix_col(mc[c]);
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < 4; c++)
         round_out[127-32*c -: 32] = mc[c] ^ round_key[127-32*c -: 32];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm        <= IDLE;
         round      <= '0;
         state      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ciphertext <= '0;
      end else begin
         done <= 1'b0;
         case (fsm)
            IDLE: begin
               round <= '0;
               if (start) begin
                  state <= plaintext ^ rk[0];
                  round <= 4'd1;
                  busy  <= 1'b1;
                  fsm   <= RUN;
               end
            end
            RUN: begin
               if (round == LAST) begin
                  ciphertext <= round_out;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  round      <= '0;
                  fsm        <= IDLE;
               end else begin
                  state <= round_out;
                  round <= round + 4'd1;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Scoreboard bench for aes_cipher_core: AES-128/192/256 instances checked
// against a byte-level AES reference model with its own key expansion.
module tb_aes_cipher_core;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_s [3];
   logic [127:0]  pt_s [3];
   logic          busy_s [3];
   logic          done_s [3];
   logic [127:0]  ct_s [3];
   logic [1407:0] fk0 = '0;
   logic [1663:0] fk1 = '0;
   logic [1919:0] fk2 = '0;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   timeouts_req = 0;
   int   timeouts_seen = 0;
   logic rst_at_edge = 1'b0;
   logic [127:0] prev_ct [3] = '{default: '0};
   logic [7:0]   sbox_t [256];

   typedef struct {
      int           inst;
      logic [127:0] ct;
      int           due;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= !rst_n;
   end

   aes_cipher_core #(.Nr(10), .Nk(4)) u_aes128 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .plaintext(pt_s[0]),
      .full_key(fk0), .busy(busy_s[0]), .done(done_s[0]), .ciphertext(ct_s[0]));
   aes_cipher_core #(.Nr(12), .Nk(6)) u_aes192 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .plaintext(pt_s[1]),
      .full_key(fk1), .busy(busy_s[1]), .done(done_s[1]), .ciphertext(ct_s[1]));
   aes_cipher_core #(.Nr(14), .Nk(8)) u_aes256 (
      .clk(clk), .rst_n(rst_n), .start(start_s[2]), .plaintext(pt_s[2]),
      .full_key(fk2), .busy(busy_s[2]), .done(done_s[2]), .ciphertext(ct_s[2]));

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] x);
      return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
   endfunction

   function automatic void expand(input logic [255:0] key, input int nk, input int nr,
                                  output logic [31:0] w [60]);
      logic [31:0] t;
      logic [7:0]  rcon = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
   endfunction

   function automatic logic [1919:0] pack(input logic [31:0] w [60], input int nk, input int nr);
      logic [1919:0] fk = '0;
      int nw = 4*(nr+1);
      int g = nk * (nw / nk);
      int off;
      for (int k = 0; k < nw; k++) begin
         if (k < g) off = 32*((nk-1-k%nk) + nk*(k/nk));
         else       off = (nr+1)*128 - 32*(k-g+1);
         fk[off +: 32] = w[k];
      end
      return fk;
   endfunction

   function automatic logic [127:0] encrypt(input logic [31:0] w [60], input int nr,
                                            input logic [127:0] pt);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr + 4*((c+rr)%4)];
         if (r != nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03);
               s[4*c+3] = gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      checks++;
      if (timeouts_req != timeouts_seen) begin
         errors++;
         $display("FAIL timeout: waits expired=%0d required=%0d", timeouts_req, timeouts_seen);
         timeouts_seen = timeouts_req;
      end
      for (int i = 0; i < 3; i++) begin
         if (rst_at_edge) begin
            checks++;
            if (busy_s[i] || done_s[i] || ct_s[i] != '0) begin
               errors++;
               $display("FAIL reset_values inst%0d: busy=%0b done=%0b ct=%h required 0/0/0",
                        i, busy_s[i], done_s[i], ct_s[i]);
            end
         end else begin
            checks++;
            if (!done_s[i] && ct_s[i] != prev_ct[i]) begin
               errors++;
               $display("FAIL ct_hold inst%0d: ct=%h required %h", i, ct_s[i], prev_ct[i]);
            end
         end
         prev_ct[i] = ct_s[i];
         if (done_s[i]) begin
            checks++;
            if (busy_s[i]) begin
               errors++;
               $display("FAIL done_busy inst%0d: busy=1 required 0", i);
            end
            checks++;
            if (sb.size() == 0 || sb[0].inst != i) begin
               errors++;
               $display("FAIL unexpected_done inst%0d: done=1 required 0 at cycle %0d", i, cyc);
            end else begin
               e = sb.pop_front();
               checks++;
               if (ct_s[i] !== e.ct) begin
                  errors++;
                  $display("FAIL ciphertext inst%0d: got %h required %h", i, ct_s[i], e.ct);
               end
               checks++;
               if (cyc != e.due) begin
                  errors++;
                  $display("FAIL latency inst%0d: done at cycle %0d required %0d", i, cyc, e.due);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int i, input logic [255:0] key, input logic [127:0] pt,
                        input bit expect_done, input bit use_kat, input logic [127:0] kat);
      logic [31:0]   w [60];
      logic [1919:0] fk;
      exp_t          e;
      int nr = 10 + 2*i;
      int nk = 4 + 2*i;
      expand(key, nk, nr, w);
      fk = pack(w, nk, nr);
      case (i)
         0:       fk0 = fk[1407:0];
         1:       fk1 = fk[1663:0];
         default: fk2 = fk;
      endcase
      pt_s[i]    = pt;
      start_s[i] = 1'b1;
      if (expect_done) begin
         e.inst = i;
         e.ct   = use_kat ? kat : encrypt(w, nr, pt);
         e.due  = cyc + nr + 1;
         sb.push_back(e);
      end
      step();
      start_s[i] = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int n = 0; n < budget && sb.size() != 0; n++) step();
      if (sb.size() != 0) begin
         timeouts_req++;
         sb.delete();
      end
   endtask

   task automatic wait_done(input int i);
      for (int n = 0; n < 40 && !done_s[i]; n++) step();
      if (!done_s[i]) timeouts_req++;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;

   initial begin
      logic [255:0] key;
      logic [7:0]   inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ rotl8(inv,1) ^ rotl8(inv,2) ^ rotl8(inv,3) ^ rotl8(inv,4) ^ 8'h63;
      end
      for (int i = 0; i < 3; i++) begin
         start_s[i] = 1'b1;
         pt_s[i]    = '0;
      end

      // reset held with start asserted
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
      step();

      issue(0, KEY_B, 128'h3243f6a8885a308d313198a2e0370734, 1, 1, 128'h3925841d02dc09fbdc118597196a0b32);
      wait_idle(30);
      issue(1, KEY_C2, PT_C, 1, 1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
      wait_idle(30);
      issue(2, KEY_C3, PT_C, 1, 1, 128'h8ea2b7ca516745bfeafc49904b496089);
      wait_idle(30);

      // ignored start mid-run, then back-to-back start in the done cycle
      issue(0, KEY_C1, PT_C, 1, 1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      repeat (3) step();
      pt_s[0] = rnd128();
      start_s[0] = 1'b1;
      step();
      start_s[0] = 1'b0;
      wait_done(0);
      issue(0, KEY_C1, rnd128(), 1, 0, '0);
      wait_idle(30);

      // abort at round 5
      issue(0, KEY_C1, PT_C, 0, 0, '0);
      repeat (4) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (16) step();
      issue(0, KEY_C1, PT_C, 1, 1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      wait_idle(30);

      // plaintext scrambled every cycle while busy
      issue(1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 64'h0}, rnd128(), 1, 0, '0);
      for (int n = 0; n < 30 && busy_s[1]; n++) begin
         pt_s[1] = rnd128();
         step();
      end
      wait_idle(30);

      // random blocks per key size, with back-to-back key changes
      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < 4; n++) begin
            key = {rnd128(), rnd128()};
            issue(i, key, rnd128(), 1, 0, '0);
            if (n % 2 == 1) begin
               wait_done(i);
               key = {rnd128(), rnd128()};
               issue(i, key, rnd128(), 1, 0, '0);
            end
            wait_idle(40);
         end
      end

      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
